// File: rtl/compresor_seq.sv
// Compressor start/stop sequencer: fan purge, run, fan run-on, anti-short-cycle lockout, fault latch.
// Build option AUTO_RESTART_EN: FAULT leaves as soon as ok clears; otherwise on must also be dropped.
module compresor_seq #(
    parameter int PRE_CYC  = 4,
    parameter int POST_CYC = 6,
    parameter int LOCK_CYC = 10,
    parameter int CNT_W    = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       on,
    input  logic       fan_only,
    input  logic [2:0] ok,
    output logic       comp_en,
    output logic       fan_en,
    output logic [2:0] state,
    output logic [2:0] fault_code
);

    typedef enum logic [2:0] {
        S_OFF   = 3'b000,
        S_PRE   = 3'b001,
        S_RUN   = 3'b010,
        S_POST  = 3'b011,
        S_LOCK  = 3'b100,
        S_FAULT = 3'b101
    } state_t;

    localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYC - 1);
    localparam logic [CNT_W-1:0] POST_LD = CNT_W'(POST_CYC - 1);
    localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       fault_q, fault_d;
    logic             comp_q, comp_d;
    logic             fan_q, fan_d;
    logic             healthy;
    logic             fault_exit;

    assign healthy = (ok == 3'b000);

`ifdef AUTO_RESTART_EN
    assign fault_exit = healthy;
`else
    assign fault_exit = healthy && !on;
`endif

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        // Counter saturates at zero; it only reloads on state entry below.
        if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        case (state_q)
            S_OFF: begin
                if (on && healthy) begin
                    state_d = S_PRE;
                    cnt_d   = PRE_LD;
                end
            end
            S_PRE: begin
                if (!on) begin
                    state_d = S_OFF;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!on) begin
                    state_d = S_POST;
                    cnt_d   = POST_LD;
                end
            end
            S_POST: begin
                if (cnt_q == '0) begin
                    state_d = S_LOCK;
                    cnt_d   = LOCK_LD;
                end
            end
            S_LOCK: begin
                if (cnt_q == '0) begin
                    if (on && healthy) begin
                        state_d = S_PRE;
                        cnt_d   = PRE_LD;
                    end else begin
                        state_d = S_OFF;
                    end
                end
            end
            S_FAULT: begin
                if (fault_exit) begin
                    state_d = S_LOCK;
                    cnt_d   = LOCK_LD;
                    fault_d = 3'b000;
                end
            end
            default: begin
                state_d = S_OFF;
                cnt_d   = '0;
                fault_d = 3'b000;
            end
        endcase

        // A fault overrides every other transition decided above.
        if (state_q != S_FAULT && !healthy) begin
            state_d = S_FAULT;
            cnt_d   = '0;
            fault_d = ok;
        end

        fan_d  = (state_d == S_PRE) || (state_d == S_RUN) || (state_d == S_POST);
        comp_d = (state_d == S_RUN) && !fan_only;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            fault_q <= 3'b000;
            comp_q  <= 1'b0;
            fan_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            comp_q  <= comp_d;
            fan_q   <= fan_d;
        end
    end

    assign state      = state_q;
    assign fault_code = fault_q;
    assign comp_en    = comp_q;
    assign fan_en     = fan_q;

endmodule
